draw_score: RTL

//  Overlay stage directly downstream of the tile renderer. Keeps two 3-digit BCD scores
//  (snake 1 / snake 2) and draws them over the incoming pixel stream in 8x16 glyphs.

---
 rtl/draw_score_if.sv | 11 +
 rtl/draw_score.sv | 121 ++++++++++++
 2 files changed

// File: rtl/draw_score_if.sv
// vga_if: VGA timing bundle passed between render stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync);
    modport slave  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/draw_score.sv
// draw_score: overlays two frame-synchronised 3-digit BCD scores on the pixel stream, 2-cycle latency.
module draw_score #(
    parameter int P1_X       = 16,
    parameter int P1_Y       = 8,
    parameter int P2_X       = 720,
    parameter int P2_Y       = 8,
    parameter int SCALE_LOG2 = 1,
    parameter int RGB_B      = 12,
    parameter logic [RGB_B-1:0] FG_COLOR = 12'hFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             point1,
    input  logic             point2,
    input  logic             clr,
    vga_if.slave             vga_in,
    input  logic [RGB_B-1:0] rgb_i,
    vga_if.master            vga_out,
    output logic [RGB_B-1:0] rgb_o
);
    localparam logic [10:0] BOX_W = 11'(24 << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(16 << SCALE_LOG2);
    localparam logic [7:0] GLYPH [160] = '{
        8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hCE,8'hDE,8'hF6,8'hE6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h0C,8'h18,8'h30,8'h60,8'hC0,8'hC6,8'hFE,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h06,8'h3C,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'hFE,8'hC0,8'hC0,8'hC0,8'hFC,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'h38,8'h60,8'hC0,8'hC0,8'hFC,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'hFE,8'hC6,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00,
        8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7E,8'h06,8'h06,8'h06,8'h0C,8'h78,8'h00,8'h00,8'h00,8'h00
    };

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        return (v == 12'h999)    ? v :
               (v[3:0] != 4'd9) ? {v[11:4], v[3:0] + 4'd1} :
               (v[7:4] != 4'd9) ? {v[11:8], v[7:4] + 4'd1, 4'd0} :
                                  {v[11:8] + 4'd1, 8'd0};
    endfunction

    logic [11:0] r_cnt1, r_cnt2, r_sh1, r_sh2;
    logic        r_vblnk_q;
    logic        r1_in, r1_blank, r1_hb, r1_vb, r1_hs, r1_vs;
    logic [3:0]  r1_dig, r1_row;
    logic [2:0]  r1_bit;
    logic [10:0] r1_h, r1_v;
    logic [RGB_B-1:0] r1_rgb;
    logic        r2_hb, r2_vb, r2_hs, r2_vs;
    logic [10:0] r2_h, r2_v;
    logic [10:0] w_dx1, w_dy1, w_dx2, w_dy2, w_dx, w_dy;
    logic        w_in1, w_in2, w_in, w_blank, w_px;
    logic [11:0] w_sh;
    logic [4:0]  w_col;
    logic [3:0]  w_row, w_dig;
    logic [7:0]  w_idx, w_glyph;

    // Unsigned wrap on the subtraction is harmless: the >= test rejects it.
    assign w_dx1 = vga_in.hcount - 11'(P1_X);
    assign w_dy1 = vga_in.vcount - 11'(P1_Y);
    assign w_dx2 = vga_in.hcount - 11'(P2_X);
    assign w_dy2 = vga_in.vcount - 11'(P2_Y);
    assign w_in1 = vga_in.hcount >= 11'(P1_X) && w_dx1 < BOX_W && vga_in.vcount >= 11'(P1_Y) && w_dy1 < BOX_H;
    assign w_in2 = vga_in.hcount >= 11'(P2_X) && w_dx2 < BOX_W && vga_in.vcount >= 11'(P2_Y) && w_dy2 < BOX_H;
    assign w_in  = w_in1 | w_in2;
    assign w_dx  = w_in1 ? w_dx1 : w_in2 ? w_dx2 : 11'd0;
    assign w_dy  = w_in1 ? w_dy1 : w_in2 ? w_dy2 : 11'd0;
    assign w_sh  = w_in1 ? r_sh1 : r_sh2;
    assign w_col = 5'(w_dx >> SCALE_LOG2);
    assign w_row = 4'(w_dy >> SCALE_LOG2);
    assign w_dig = (w_col[4:3] == 2'd0) ? w_sh[11:8] : (w_col[4:3] == 2'd1) ? w_sh[7:4] : w_sh[3:0];
    assign w_blank = (w_col[4:3] == 2'd0 && w_sh[11:8] == 4'd0) || (w_col[4:3] == 2'd1 && w_sh[11:4] == 8'd0);
    assign w_idx   = (r1_in && r1_dig < 4'd10) ? {r1_dig, r1_row} : 8'd0;
    assign w_glyph = GLYPH[w_idx];
    assign w_px    = w_glyph[3'd7 - r1_bit];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_sh1     <= '0;
            r_sh2     <= '0;
            r_vblnk_q <= 1'b0;
        end else begin
            r_cnt1    <= clr ? 12'h000 : point1 ? bcd_inc(r_cnt1) : r_cnt1;
            r_cnt2    <= clr ? 12'h000 : point2 ? bcd_inc(r_cnt2) : r_cnt2;
            r_vblnk_q <= vga_in.vblnk;
            if (vga_in.vblnk && !r_vblnk_q) begin
                r_sh1 <= r_cnt1;
                r_sh2 <= r_cnt2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            {r1_in, r1_blank, r1_dig, r1_row, r1_bit, r1_rgb} <= '0;
            {r1_h, r1_v, r1_hb, r1_vb, r1_hs, r1_vs}          <= '0;
            {r2_h, r2_v, r2_hb, r2_vb, r2_hs, r2_vs, rgb_o}   <= '0;
        end else begin
            r1_in    <= w_in;
            r1_blank <= w_blank;
            r1_dig   <= w_dig;
            r1_row   <= w_row;
            r1_bit   <= w_col[2:0];
            r1_rgb   <= rgb_i;
            {r1_h, r1_v, r1_hb, r1_vb, r1_hs, r1_vs} <=
                {vga_in.hcount, vga_in.vcount, vga_in.hblnk, vga_in.vblnk, vga_in.hsync, vga_in.vsync};
            {r2_h, r2_v, r2_hb, r2_vb, r2_hs, r2_vs} <= {r1_h, r1_v, r1_hb, r1_vb, r1_hs, r1_vs};
            rgb_o <= (r1_in && !r1_blank && w_px && !r1_hb && !r1_vb) ? FG_COLOR : r1_rgb;
        end
    end

    assign vga_out.hcount = r2_h;
    assign vga_out.vcount = r2_v;
    assign vga_out.hblnk  = r2_hb;
    assign vga_out.vblnk  = r2_vb;
    assign vga_out.hsync  = r2_hs;
    assign vga_out.vsync  = r2_vs;
endmodule
